peripheral_mpram_req_bridge: RTL and testbench

//  Upstream front-end for the single-port peripheral RAM. Converts a valid/ready

---
 rtl/peripheral_mpram_req_bridge.sv | 77 +++++++
 tb/tb_peripheral_mpram_req_bridge.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/peripheral_mpram_req_bridge.sv
// Valid/ready front-end for the single-port peripheral RAM: converts requests into
// active-low RAM strobes, tracks the 1-cycle read latency and holds the response.
module peripheral_mpram_req_bridge #(
   parameter int AW       = 8,
   parameter int DW       = 16,
   parameter int MEM_SIZE = 256
) (
   input  logic          ram_clk,
   input  logic          ram_rstn,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [1:0]    req_be,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   output logic          ram_cen,
   output logic [1:0]    ram_wen,
   input  logic [DW-1:0] ram_dout
);

   localparam int unsigned WORDS = MEM_SIZE / 2;

   typedef enum logic [1:0] {IDLE, RD_WAIT, RSP} state_t;

   state_t state, state_nxt, state_acc;
   logic   acc, oor;

   assign oor = (32'(req_addr) >= WORDS);
   // Only in-range reads need the latency stage; writes and errors answer directly.
   assign state_acc = (~req_we & ~oor) ? RD_WAIT : RSP;

   always_ff @(posedge ram_clk or negedge ram_rstn) begin
      if (!ram_rstn) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (acc) state_nxt = state_acc;
         RD_WAIT: state_nxt = RSP;
         RSP:     if (rsp_ready) state_nxt = acc ? state_acc : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      // Gating with reset keeps the RAM quiet while reset is held.
      req_ready = ram_rstn & ((state == IDLE) | ((state == RSP) & rsp_ready));
      acc       = req_valid & req_ready;
      rsp_valid = (state == RSP);
      ram_addr  = req_addr;
      ram_din   = req_wdata;
      ram_cen   = ~(acc & ~oor & (~req_we | (req_be != 2'b00)));
      ram_wen   = (acc & ~oor & req_we) ? ~req_be : 2'b11;
   end

   always_ff @(posedge ram_clk or negedge ram_rstn) begin
      if (!ram_rstn) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (acc) begin
         rsp_rdata <= '0;
         rsp_err   <= oor;
      end else if (state == RD_WAIT) begin
         rsp_rdata <= ram_dout;
         rsp_err   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_peripheral_mpram_req_bridge.sv
// Directed plus random traffic against a word-level reference memory; the RAM itself
// is a simple behavioural device hung off the strobes.
module tb_peripheral_mpram_req_bridge;

   logic        ram_clk = 1'b0;
   logic        ram_rstn;
   logic        req_valid, req_ready, req_we;
   logic [1:0]  req_be;
   logic [7:0]  req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [15:0] rsp_rdata;
   logic [7:0]  ram_addr;
   logic [15:0] ram_din, ram_dout;
   logic        ram_cen;
   logic [1:0]  ram_wen;

   int checks = 0;
   int failures = 0;

   peripheral_mpram_req_bridge #(.AW(8), .DW(16), .MEM_SIZE(256)) dut (
      .ram_clk(ram_clk), .ram_rstn(ram_rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_be(req_be),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_cen(ram_cen), .ram_wen(ram_wen),
      .ram_dout(ram_dout)
   );

   always #5 ram_clk = ~ram_clk;

   // Behavioural single-port RAM device (environment, not the reference)
   logic [15:0] ram_mem [256];
   initial begin
      for (int i = 0; i < 256; i++) ram_mem[i] = 16'h0;
      ram_dout = 16'h0;
   end
   always @(posedge ram_clk) begin
      if (!ram_cen) begin
         if (!ram_wen[0]) ram_mem[ram_addr][7:0]  <= ram_din[7:0];
         if (!ram_wen[1]) ram_mem[ram_addr][15:8] <= ram_din[15:8];
         if (&ram_wen)    ram_dout <= ram_mem[ram_addr];
      end
   end

   // Reference model: 128 legal words, updated at acceptance
   logic [15:0] ref_mem [128];
   logic [15:0] exp_rdata;
   logic        exp_err;
   bit          pend = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1. Issues one request; when a response is pending, rsp_ready
   // is raised in the same cycle so the old response retires on the accept edge.
   task automatic send(input logic we, input logic [1:0] be, input logic [7:0] addr,
                       input logic [15:0] wdata);
      bit got, oor, rd;
      logic [15:0] m;
      req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
      rsp_ready = pend;
      got = 0;
      for (int n = 0; n < 20; n++) begin
         #3;
         if (req_ready === 1'b1) begin got = 1; break; end
         @(posedge ram_clk); #1;
      end
      check("req_ready_wait", {31'b0, got}, 32'd1);
      oor = (addr >= 8'd128);
      rd  = !we && !oor;
      check("ram_cen", {31'b0, ram_cen}, {31'b0, (oor || (we && be == 2'b00))});
      check("ram_wen", {30'b0, ram_wen}, {30'b0, (we && !oor) ? ~be : 2'b11});
      if (!ram_cen) check("ram_addr", {24'b0, ram_addr}, {24'b0, addr});
      exp_err   = oor;
      exp_rdata = rd ? ref_mem[addr[6:0]] : 16'h0;
      if (we && !oor) begin
         m = ref_mem[addr[6:0]];
         if (be[0]) m[7:0]  = wdata[7:0];
         if (be[1]) m[15:8] = wdata[15:8];
         ref_mem[addr[6:0]] = m;
      end
      @(posedge ram_clk); #1;
      req_valid = 1'b0; rsp_ready = 1'b0;
      check("rsp_valid_edge1", {31'b0, rsp_valid}, {31'b0, !rd});
      if (rd) begin
         @(posedge ram_clk); #1;
         check("rsp_valid_edge2", {31'b0, rsp_valid}, 32'd1);
      end
      check("rsp_rdata", {16'b0, rsp_rdata}, {16'b0, exp_rdata});
      check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
      pend = 1;
   endtask

   task automatic hold(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge ram_clk); #3;
         check("hold_rdata", {16'b0, rsp_rdata}, {16'b0, exp_rdata});
         check("hold_valid", {31'b0, rsp_valid}, 32'd1);
         check("hold_ready", {31'b0, req_ready}, 32'd0);
         #1;
      end
   endtask

   task automatic retire();
      rsp_ready = 1'b1;
      @(posedge ram_clk); #1;
      rsp_ready = 1'b0;
      check("retire_valid", {31'b0, rsp_valid}, 32'd0);
      pend = 0;
   endtask

   initial begin
      logic [7:0] a;
      for (int i = 0; i < 128; i++) ref_mem[i] = 16'h0;
      // Reset with a request pending
      ram_rstn = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_be = 2'b11;
      req_addr = 8'd5; req_wdata = 16'hFFFF; rsp_ready = 1'b0;
      repeat (2) @(posedge ram_clk);
      #3;
      check("rst_cen", {31'b0, ram_cen}, 32'd1);
      check("rst_wen", {30'b0, ram_wen}, 32'd3);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_req_ready", {31'b0, req_ready}, 32'd0);
      check("rst_rdata", {16'b0, rsp_rdata}, 32'd0);
      check("rst_err", {31'b0, rsp_err}, 32'd0);
      req_valid = 1'b0;
      ram_rstn = 1'b1;
      @(posedge ram_clk); #1;

      // Full write, read back, byte write, read back
      send(1'b1, 2'b11, 8'd5, 16'hA5C3); retire();
      send(1'b0, 2'b00, 8'd5, 16'h0);    retire();
      check("rd_a5c3", {16'b0, exp_rdata}, 32'hA5C3);
      send(1'b1, 2'b01, 8'd5, 16'h1234); retire();
      send(1'b0, 2'b11, 8'd5, 16'h0);    retire();
      check("rd_a534", {16'b0, exp_rdata}, 32'hA534);

      // Out-of-range read and write
      send(1'b0, 2'b11, 8'd128, 16'h0);    retire();
      send(1'b1, 2'b11, 8'd200, 16'hBEEF); retire();
      send(1'b0, 2'b11, 8'd72, 16'h0);     retire();

      // Backpressure on a read, then back-to-back issue in the retire cycle
      send(1'b0, 2'b11, 8'd5, 16'h0);
      hold(5);
      send(1'b1, 2'b10, 8'd6, 16'h7788);
      send(1'b0, 2'b11, 8'd6, 16'h0);
      // Empty-strobe write is acked but leaves memory alone
      send(1'b1, 2'b00, 8'd6, 16'hFFFF);
      send(1'b0, 2'b11, 8'd6, 16'h0);
      retire();
      check("rd_7700", {16'b0, exp_rdata}, 32'h7700);

      // Reset while a read is in flight: no response appears
      req_valid = 1'b1; req_we = 1'b0; req_be = 2'b11; req_addr = 8'd5;
      #3;
      check("pre_rst_ready", {31'b0, req_ready}, 32'd1);
      @(posedge ram_clk); #1;
      req_valid = 1'b0;
      ram_rstn = 1'b0;
      #2;
      ram_rstn = 1'b1;
      repeat (2) begin
         @(posedge ram_clk); #1;
         check("abandon_valid", {31'b0, rsp_valid}, 32'd0);
      end

      // Random back-to-back traffic
      for (int t = 0; t < 60; t++) begin
         a = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(120, 255)) : 8'($urandom_range(0, 15));
         send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, 16'($urandom));
         if ($urandom_range(0, 3) == 0) hold($urandom_range(1, 2));
         if ($urandom_range(0, 2) == 0) retire();
      end
      if (pend) retire();
      for (int i = 0; i < 16; i++) begin
         send(1'b0, 2'b11, 8'(i), 16'h0);
         retire();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
